// File: rtl/sprite_pixel_fetch_pkg.sv
// Shared constants and types for the sprite pixel fetch pipeline.
package sprite_pixel_fetch_pkg;

  localparam int COLOR_W_DEF     = 9;
  localparam int COLLISION_CNT_W = 8;
  localparam logic [8:0] TRANSPARENT_KEY = 9'h1C7;

  // Which source feeds the pixel once it reaches the output stage.
  typedef enum logic [1:0] {
    PIX_BLANK  = 2'd0,
    PIX_BG     = 2'd1,
    PIX_SPRITE = 2'd2
  } pix_src_e;

endpackage

// File: rtl/sprite_priority_arbiter.sv
// Fixed-priority sprite selector: the lowest-index requester wins; multi_hit
// flags two or more simultaneous requests.
module sprite_priority_arbiter
  import sprite_pixel_fetch_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int IDX_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic [NUM_SPRITES-1:0] req,
  output logic [IDX_W-1:0]       winner,
  output logic                   hit,
  output logic                   multi_hit
);

  always_comb begin
    winner    = '0;
    hit       = 1'b0;
    multi_hit = 1'b0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (req[i]) begin
        if (hit) begin
          multi_hit = 1'b1;
        end else begin
          winner = IDX_W'(i);
          hit    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sprite_pixel_fetch.sv
// Two-stage sprite pixel pipeline: priority select, memory read, color mux.
// Define SPRITE_TRANSPARENCY_EN to show the background through TRANSPARENT_KEY.
module sprite_pixel_fetch
  import sprite_pixel_fetch_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int ADDR_W      = 10,
  parameter int ELEM_W      = 4,
  parameter int COLOR_W     = COLOR_W_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SPRITES-1:0]        sp_enable,
  input  logic [NUM_SPRITES*ADDR_W-1:0] sp_address,
  input  logic [NUM_SPRITES*ELEM_W-1:0] sp_element,
  input  logic                          video_enable,
  input  logic [COLOR_W-1:0]            bg_color,
  output logic                          mem_rd,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [ELEM_W-1:0]             mem_elem,
  input  logic [COLOR_W-1:0]            mem_rdata,
  input  logic                          collision_clr,
  output logic [COLOR_W-1:0]            rgb_out,
  output logic                          rgb_valid,
  output logic                          collision,
  output logic [COLLISION_CNT_W-1:0]    collision_count
);

  localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

  function automatic logic [COLLISION_CNT_W-1:0] sat_inc(input logic [COLLISION_CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  function automatic logic [COLOR_W-1:0] pick_pixel(input pix_src_e src,
                                                    input logic [COLOR_W-1:0] rdata,
                                                    input logic [COLOR_W-1:0] bg);
    case (src)
`ifdef SPRITE_TRANSPARENCY_EN
      PIX_SPRITE: return (rdata == COLOR_W'(TRANSPARENT_KEY)) ? bg : rdata;
`else
      PIX_SPRITE: return rdata;
`endif
      PIX_BG:     return bg;
      default:    return '0;
    endcase
  endfunction

  logic [NUM_SPRITES-1:0] req_p0;
  logic [IDX_W-1:0]       winner_p0;
  logic                   hit_p0;
  logic                   multi_p0;
  pix_src_e               src_p0;

  // Stage 0: qualify requests with the active region and pick the winner.
  assign req_p0 = sp_enable & {NUM_SPRITES{video_enable}};

  sprite_priority_arbiter #(
    .NUM_SPRITES (NUM_SPRITES),
    .IDX_W       (IDX_W)
  ) u_arb (
    .req       (req_p0),
    .winner    (winner_p0),
    .hit       (hit_p0),
    .multi_hit (multi_p0)
  );

  assign src_p0 = !video_enable ? PIX_BLANK : (hit_p0 ? PIX_SPRITE : PIX_BG);

  logic                vld_p1, vld_p2;
  pix_src_e            src_p1, src_p2;
  logic [COLOR_W-1:0]  bg_p1, bg_p2;

  // Stage 1: issue the memory read; Stage 2: mux the returned word.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      mem_elem <= '0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      src_p1   <= PIX_BLANK;
      src_p2   <= PIX_BLANK;
    end else begin
      mem_rd <= hit_p0;
      if (hit_p0) begin
        mem_addr <= sp_address[winner_p0*ADDR_W +: ADDR_W];
        mem_elem <= sp_element[winner_p0*ELEM_W +: ELEM_W];
      end
      vld_p1 <= video_enable;
      src_p1 <= src_p0;
      vld_p2 <= vld_p1;
      src_p2 <= src_p1;
    end
  end

  always_ff @(posedge clk) begin
    bg_p1 <= bg_color;
    bg_p2 <= bg_p1;
  end

  // Read data arrives one cycle after mem_rd, so the final mux is combinational.
  always_comb rgb_out = pick_pixel(src_p2, mem_rdata, bg_p2);
  assign rgb_valid = vld_p2;

  // A clear coinciding with a new overlap restarts the count at one.
  always_ff @(posedge clk) begin
    if (reset) begin
      collision       <= 1'b0;
      collision_count <= '0;
    end else if (collision_clr) begin
      collision       <= multi_p0;
      collision_count <= multi_p0 ? COLLISION_CNT_W'(1) : '0;
    end else if (multi_p0) begin
      collision       <= 1'b1;
      collision_count <= sat_inc(collision_count);
    end
  end

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Directed bench for sprite_pixel_fetch: vector table plus multi-cycle sequences.
module tb_sprite_pixel_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  sp_enable;
  logic [39:0] sp_address;
  logic [15:0] sp_element;
  logic        video_enable;
  logic [8:0]  bg_color;
  logic        mem_rd;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_elem;
  logic [8:0]  mem_rdata = '0;
  logic        collision_clr;
  logic [8:0]  rgb_out;
  logic        rgb_valid;
  logic        collision;
  logic [7:0]  collision_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sprite_pixel_fetch dut (
    .clk             (clk),
    .reset           (reset),
    .sp_enable       (sp_enable),
    .sp_address      (sp_address),
    .sp_element      (sp_element),
    .video_enable    (video_enable),
    .bg_color        (bg_color),
    .mem_rd          (mem_rd),
    .mem_addr        (mem_addr),
    .mem_elem        (mem_elem),
    .mem_rdata       (mem_rdata),
    .collision_clr   (collision_clr),
    .rgb_out         (rgb_out),
    .rgb_valid       (rgb_valid),
    .collision       (collision),
    .collision_count (collision_count)
  );

  // Sprite memory: registered read, contents = addr[8:0] ^ elem.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem_addr[8:0] ^ {5'b0, mem_elem};
  end

  typedef struct {
    logic       ve;
    logic [3:0] sp;
    logic [8:0] bg;
    logic       rd;
    logic [9:0] addr;
    logic [3:0] elem;
    logic [8:0] rgb;
    logic       vld;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_rd"}, 32'(mem_rd), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_elem"}, 32'(mem_elem), 0);
    chk({tag, "_rgb_out"}, 32'(rgb_out), 0);
    chk({tag, "_rgb_valid"}, 32'(rgb_valid), 0);
    chk({tag, "_collision"}, 32'(collision), 0);
    chk({tag, "_count"}, 32'(collision_count), 0);
  endtask

  task automatic idle();
    video_enable = 1'b0;
    sp_enable    = 4'b0000;
  endtask

  initial begin
    logic [8:0] key_exp;
`ifdef SPRITE_TRANSPARENCY_EN
    key_exp = 9'h155;
`else
    key_exp = 9'h1C7;
`endif
    // sprite3..0 addresses and banks; memory words: s0=00D s1=010 s2=024 s3=1C7
    sp_address = {10'h1C7, 10'd37, 10'd20, 10'd5};
    sp_element = {4'b0000, 4'b0001, 4'b0100, 4'b1000};
    //          ve   sp       bg      rd    addr     elem     rgb      vld   cnt
    vecs[0] = '{1'b1, 4'b0100, 9'h049, 1'b1, 10'd37,  4'b0001, 9'h024,  1'b1, 8'd0};
    vecs[1] = '{1'b1, 4'b0000, 9'h049, 1'b0, 10'd37,  4'b0001, 9'h049,  1'b1, 8'd0};
    vecs[2] = '{1'b0, 4'b1111, 9'h049, 1'b0, 10'd37,  4'b0001, 9'h000,  1'b0, 8'd0};
    vecs[3] = '{1'b1, 4'b1010, 9'h0AA, 1'b1, 10'd20,  4'b0100, 9'h010,  1'b1, 8'd1};
    vecs[4] = '{1'b1, 4'b1000, 9'h155, 1'b1, 10'h1C7, 4'b0000, key_exp, 1'b1, 8'd1};
    vecs[5] = '{1'b1, 4'b0001, 9'h0F0, 1'b1, 10'd5,   4'b1000, 9'h00D,  1'b1, 8'd1};
    vecs[6] = '{1'b1, 4'b1111, 9'h0F0, 1'b1, 10'd5,   4'b1000, 9'h00D,  1'b1, 8'd2};

    reset = 1'b1; collision_clr = 1'b0; bg_color = 9'h049;
    video_enable = 1'b1; sp_enable = 4'b1111;
    step(); step();
    chk_all_zero("reset");
    reset = 1'b0;
    idle();
    step(); step();

    for (int i = 0; i < 7; i++) begin
      video_enable = vecs[i].ve;
      sp_enable    = vecs[i].sp;
      bg_color     = vecs[i].bg;
      step();
      chk($sformatf("v%0d_mem_rd", i), 32'(mem_rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].addr));
      chk($sformatf("v%0d_mem_elem", i), 32'(mem_elem), 32'(vecs[i].elem));
      chk($sformatf("v%0d_count", i), 32'(collision_count), 32'(vecs[i].cnt));
      idle();
      bg_color = 9'h1FF;
      step();
      chk($sformatf("v%0d_rgb_out", i), 32'(rgb_out), 32'(vecs[i].rgb));
      chk($sformatf("v%0d_rgb_valid", i), 32'(rgb_valid), 32'(vecs[i].vld));
    end

    // Clear, then three back-to-back overlapping pixels.
    collision_clr = 1'b1; step(); collision_clr = 1'b0;
    chk("clr_collision", 32'(collision), 0);
    chk("clr_count", 32'(collision_count), 0);
    video_enable = 1'b1; sp_enable = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("ovl%0d_mem_rd", i), 32'(mem_rd), 1);
      chk($sformatf("ovl%0d_mem_addr", i), 32'(mem_addr), 20);
      if (i > 0) chk($sformatf("ovl%0d_rgb_out", i), 32'(rgb_out), 32'h010);
    end
    idle(); step();
    chk("ovl_collision", 32'(collision), 1);
    chk("ovl_count", 32'(collision_count), 3);
    chk("ovl_rgb_last", 32'(rgb_out), 32'h010);

    collision_clr = 1'b1; step(); collision_clr = 1'b0;
    chk("clr2_collision", 32'(collision), 0);
    chk("clr2_count", 32'(collision_count), 0);

    // Clear in the same cycle as a new overlap.
    collision_clr = 1'b1; video_enable = 1'b1; sp_enable = 4'b0110;
    step();
    collision_clr = 1'b0; idle();
    chk("clrhit_collision", 32'(collision), 1);
    chk("clrhit_count", 32'(collision_count), 1);
    step();

    // Saturation after 300 overlap cycles.
    collision_clr = 1'b1; step(); collision_clr = 1'b0;
    video_enable = 1'b1; sp_enable = 4'b1001;
    for (int i = 0; i < 300; i++) step();
    idle(); step();
    chk("sat_count", 32'(collision_count), 255);
    chk("sat_collision", 32'(collision), 1);

    // Reset mid-stream.
    video_enable = 1'b1; sp_enable = 4'b0100; bg_color = 9'h049;
    step(); step();
    reset = 1'b1;
    step();
    chk_all_zero("midrst");
    reset = 1'b0;
    step();
    chk("post_rst_vld1", 32'(rgb_valid), 0);
    chk("post_rst_rd1", 32'(mem_rd), 1);
    step();
    chk("post_rst_vld2", 32'(rgb_valid), 1);
    chk("post_rst_rgb2", 32'(rgb_out), 32'h024);
    chk("post_rst_count", 32'(collision_count), 0);
    idle(); step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
